// File: rtl/freespace_update_arbiter_pkg.sv
// Shared constants and output-slot state encoding for the freespace update merger.
package freespace_update_arbiter_pkg;

    localparam int DEFAULT_PACKET_BITS = 97;
    localparam int DEFAULT_VALID_BIT   = DEFAULT_PACKET_BITS - 1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/freespace_update_arbiter_rr.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ  = 7,
    parameter int IDX_BITS = 3
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [IDX_BITS-1:0] ptr,
    input  logic                enable,
    output logic [NUM_REQ-1:0]  grant,
    output logic [IDX_BITS-1:0] grant_idx,
    output logic                grant_valid
);

    always_comb begin : search
        int                cand;
        logic [IDX_BITS-1:0] cand_idx;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        if (enable) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand     = (int'(ptr) + k) % NUM_REQ;
                cand_idx = IDX_BITS'(cand);
                if (!grant_valid && req[cand_idx]) begin
                    grant_valid     = 1'b1;
                    grant[cand_idx] = 1'b1;
                    grant_idx       = cand_idx;
                end
            end
        end
    end

endmodule

// File: rtl/freespace_update_arbiter.sv
// Merges per-port freespace credit packets into one registered stream with
// per-port coalescing hold registers and round-robin arbitration.
module freespace_update_arbiter
    import freespace_update_arbiter_pkg::*;
#(
    parameter int PACKET_BITS   = DEFAULT_PACKET_BITS,
    parameter int NUM_IN_PORTS  = 7,
    parameter int PORT_IDX_BITS = 3,
    parameter int CNT_BITS      = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_IN_PORTS-1:0]           freespace_update,
    input  logic [PACKET_BITS*NUM_IN_PORTS-1:0] packet_from_input_ports,
    output logic [PACKET_BITS-1:0]            stream_out,
    input  logic                              out_ack,
    output logic [NUM_IN_PORTS-1:0]           pending,
    output logic [CNT_BITS*NUM_IN_PORTS-1:0]  coalesce_cnt,
    output logic                              arb_busy
);

    localparam int VALID_BIT = PACKET_BITS - 1;
    localparam logic [PORT_IDX_BITS-1:0] RR_RESET = PORT_IDX_BITS'(NUM_IN_PORTS - 1);

    slot_state_e                slot_state;
    slot_state_e                slot_next;
    logic                       slot_full;
    logic                       slot_free;
    logic [VALID_BIT-1:0]       out_payload;
    logic [PORT_IDX_BITS-1:0]   rr_ptr;
    logic [NUM_IN_PORTS-1:0]    grant;
    logic [PORT_IDX_BITS-1:0]   grant_idx;
    logic                       grant_valid;
    logic [PACKET_BITS-1:0]     hold_pkt [NUM_IN_PORTS];

    rr_arbiter #(
        .NUM_REQ  (NUM_IN_PORTS),
        .IDX_BITS (PORT_IDX_BITS)
    ) u_rr (
        .req         (pending),
        .ptr         (rr_ptr),
        .enable      (slot_free),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_state <= SLOT_EMPTY;
        end else begin
            slot_state <= slot_next;
        end
    end

    always_comb begin
        slot_next = slot_state;
        if (grant_valid) begin
            slot_next = SLOT_FULL;
        end else if (slot_state == SLOT_FULL && out_ack) begin
            slot_next = SLOT_EMPTY;
        end
    end

    // The slot can take a new packet in the same cycle its current one is acked.
    always_comb begin
        slot_full = (slot_state == SLOT_FULL);
        slot_free = !slot_full || out_ack;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_payload <= '0;
            rr_ptr      <= RR_RESET;
        end else if (grant_valid) begin
            out_payload <= hold_pkt[grant_idx][VALID_BIT-1:0];
            rr_ptr      <= grant_idx;
        end
    end

    assign stream_out = {slot_full, out_payload};
    assign arb_busy   = (|pending) | slot_full;

    for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_port
        logic [PACKET_BITS-1:0] hold_q;
        logic                   pend_q;
        logic [CNT_BITS-1:0]    cnt_q;

        // An update that lands while the old packet is leaving is not a coalesce.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                hold_q <= '0;
                pend_q <= 1'b0;
                cnt_q  <= '0;
            end else if (freespace_update[i]) begin
                hold_q <= packet_from_input_ports[PACKET_BITS*i +: PACKET_BITS];
                pend_q <= 1'b1;
                if (pend_q && !grant[i] && cnt_q != {CNT_BITS{1'b1}}) begin
                    cnt_q <= cnt_q + CNT_BITS'(1);
                end
            end else if (grant[i]) begin
                pend_q <= 1'b0;
            end
        end

        assign hold_pkt[i]                        = hold_q;
        assign pending[i]                         = pend_q;
        assign coalesce_cnt[CNT_BITS*i +: CNT_BITS] = cnt_q;
    end

endmodule

// File: doc/freespace_update_arbiter.md
Name: freespace_update_arbiter

Overview:
- Consumes the per-port freespace (credit) packets raised by the input-port cluster: `freespace_update[i]` plus the matching slice of `packet_from_input_ports`.
- Merges them into a single packet stream towards the leaf interface, which returns them to the upstream BFT.
- Holds one pending packet per port and arbitrates round-robin into a registered output slot with a valid/ack handshake.
- A newer update for a port supersedes its older, still-pending update (coalescing).

Parameters:
- PACKET_BITS, 97, width of one packet; bit PACKET_BITS-1 is the packet valid bit.
- NUM_IN_PORTS, 7, number of input ports feeding updates.
- PORT_IDX_BITS, 3, width of the round-robin pointer; must satisfy 2**PORT_IDX_BITS >= NUM_IN_PORTS.
- CNT_BITS, 16, width of each per-port coalesce counter.

Ports:
- clk  input  1  single clock, shared with the cluster's clk domain.
- reset  input  1  asynchronous, active-low reset.
- freespace_update  input  NUM_IN_PORTS  per-port one-cycle strobe, a new packet is present.
- packet_from_input_ports  input  PACKET_BITS*NUM_IN_PORTS  port i occupies [PACKET_BITS*(i+1)-1 : PACKET_BITS*i].
- stream_out  output  PACKET_BITS  registered output packet; MSB is the valid bit.
- out_ack  input  1  leaf interface accepted stream_out this cycle.
- pending  output  NUM_IN_PORTS  per-port holding-register-valid flags.
- coalesce_cnt  output  CNT_BITS*NUM_IN_PORTS  per-port count of overwritten (superseded) updates.
- arb_busy  output  1  high when any pending bit is set or stream_out is valid.

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - all hold registers, pending, and coalesce_cnt;
  - stream_out to all zeros;
  - arb_busy to 0;
  - rr_ptr to NUM_IN_PORTS-1, so port 0 has first priority.
- Per-port hold register, updated at each posedge:
  - If freespace_update[i]=1: capture the packet slice and set pending[i]=1.
  - Otherwise, if port i is granted this cycle: clear pending[i].
  - If pending[i]=1 and port i is not granted this cycle, the new capture overwrites the old one and coalesce_cnt[i] increments, saturating at all-ones.
  - If port i is granted in the same cycle an update arrives, the old packet moves to the output, the new one is captured, pending[i] stays 1, and coalesce_cnt[i] does not increment.
- Output slot, two states:
  - EMPTY: stream_out MSB=0.
  - FULL: stream_out MSB=1 and stream_out is held stable until out_ack=1.
  - slot_free = EMPTY, or FULL with out_ack=1 in the same cycle.
  - out_ack while EMPTY is ignored.
- Arbitration (combinational, on registered pending):
  - When slot_free and any pending bit is set, grant the first pending port found searching rr_ptr+1, rr_ptr+2, ... with modulo NUM_IN_PORTS wrap.
  - At the edge, load stream_out with that port's hold packet, go to (or stay in) FULL, and set rr_ptr to the granted index.
  - No grant: FULL with ack goes to EMPTY; otherwise the state holds.
- Latency:
  - Update asserted in cycle t with the slot free: stream_out becomes valid after edge t+1, i.e. 2 cycles.
  - Back-to-back throughput is 1 packet/cycle while out_ack is held high.
- Fairness: with all ports pending and continuous ack, the output order is 0,1,...,N-1,0,...; no port waits more than NUM_IN_PORTS grants.
- arb_busy = |pending | stream_out[PACKET_BITS-1], registered-derived with no combinational path from inputs. It is used as the stall/drain indicator in done mode.
- Packet contents pass through unmodified; no width conversion.

Decomposition:
- Shared package: PACKET_BITS / valid-bit index constant and the output-state encoding (EMPTY=0, FULL=1).
- Natural sub-module: rr_arbiter (request vector plus pointer in; one-hot grant and index out; purely combinational), reusable by other leaf-interface mergers.
- Hold registers and counters are a generate loop in the top module.

Test Plan:
- Reset: drive reset=0 mid-traffic with stream_out valid and pending=7'h7F -> within the same cycle stream_out=0, pending=0, coalesce_cnt=0; after release, the first grant goes to port 0.
- Single update: freespace_update=7'b0000100 with packet 97'h1_0000_...ABCD in cycle 5, out_ack=1 -> stream_out equals that packet after edge 6, valid for one cycle, pending[2] cleared after edge 6.
- Fairness: all 7 ports strobed in the same cycle, out_ack=1 -> output order ports 0..6 over 7 consecutive cycles, then arb_busy=0.
- Backpressure: out_ack=0 for 10 cycles with ports 1 and 3 pending -> stream_out stable (port 1 packet); ack at cycle 11 -> port 3 appears the next cycle.
- Coalescing: port 4 strobed 3 times while the output is stalled -> only the third packet is emitted; coalesce_cnt[4]=2.
- Grant/update collision: port 0 granted in the same cycle a new port-0 update arrives -> old packet output, new one pending, coalesce_cnt[0] unchanged; saturation check with CNT_BITS=2 after 5 overwrites -> coalesce_cnt[0]=3.
